// File: rtl/activity_predictor_if.sv
// Signal bundle between the datapath/power controller and activity_predictor.
// The master drives the activity strobes and the slave (the predictor) returns the hint and status.
interface activity_predictor_if;
  // activity and wake_req are level strobes sampled on every rising clk edge.
  // There is no valid/ready pair: the predictor accepts every cycle and never back-pressures.
  logic        activity;
  logic        wake_req;
  logic        predict;
  logic [1:0]  state;
  logic [15:0] sleep_count;

  modport master (
    output activity,
    output wake_req,
    input  predict,
    input  state,
    input  sleep_count
  );

  modport slave (
    input  activity,
    input  wake_req,
    output predict,
    output state,
    output sleep_count
  );
endinterface

// File: rtl/activity_predictor.sv
// Clock-gating hint generator: saturating activity score, warm-up, idle-drain timeout and wake.
// Define ACT_PRED_STATS_EN to build the saturating sleep_count counter; otherwise sleep_count reads 0.
module activity_predictor #(
  parameter int CNT_W      = 4,
  parameter int ON_THRESH  = 2,
  parameter int IDLE_LIMIT = 8,
  parameter int WARMUP     = 4
) (
  input logic               clk,
  input logic               reset,
  activity_predictor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SLEEP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SCORE_MAX = '1;
  localparam logic [CNT_W-1:0] ON_TH     = CNT_W'(ON_THRESH);
  localparam logic [15:0]      WARM_LAST = 16'(WARMUP - 1);
  localparam logic [15:0]      IDLE_LAST = 16'(IDLE_LIMIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] score_q, score_d;
  logic [15:0]      warm_cnt_q, warm_cnt_d;
  logic [15:0]      idle_cnt_q, idle_cnt_d;
  logic             predict_q, predict_d;
  logic             wake;

  // Either strobe is a wake; both together behave as one.
  assign wake = bus.activity | bus.wake_req;

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = '0;
    idle_cnt_d = '0;
    score_d    = score_q;

    if (bus.activity) begin
      if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
    end else begin
      if (score_q != '0) score_d = score_q - 1'b1;
    end

    // Transition tests look at the registered score, not score_d.
    case (state_q)
      ST_WARMUP: begin
        if (warm_cnt_q == WARM_LAST) state_d = ST_ACTIVE;
        else                         warm_cnt_d = warm_cnt_q + 16'd1;
      end
      ST_ACTIVE: begin
        if (!wake && (score_q < ON_TH)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A wake on the final idle cycle still wins over the timeout.
        if (wake)                          state_d = ST_ACTIVE;
        else if (idle_cnt_q == IDLE_LAST)  state_d = ST_SLEEP;
        else                               idle_cnt_d = idle_cnt_q + 16'd1;
      end
      ST_SLEEP: begin
        if (wake) state_d = ST_ACTIVE;
      end
    endcase

    predict_d = (state_d != ST_SLEEP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_WARMUP;
      score_q    <= '0;
      warm_cnt_q <= '0;
      idle_cnt_q <= '0;
      predict_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      warm_cnt_q <= warm_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      predict_q  <= predict_d;
    end
  end

`ifdef ACT_PRED_STATS_EN
  logic [15:0] sleep_count_q, sleep_count_d;
  logic        sleep_entry;

  assign sleep_entry = (state_q == ST_DRAIN) && (state_d == ST_SLEEP);

  always_comb begin
    sleep_count_d = sleep_count_q;
    if (sleep_entry && (sleep_count_q != 16'hFFFF)) sleep_count_d = sleep_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sleep_count_q <= '0;
    else       sleep_count_q <= sleep_count_d;
  end

  assign bus.sleep_count = sleep_count_q;
`else
  assign bus.sleep_count = 16'h0000;
`endif

  assign bus.state   = state_q;
  assign bus.predict = predict_q;

endmodule

// File: tb/tb_activity_predictor.sv
// Self-checking bench for activity_predictor: directed scenarios with literal checks, then
// randomized strobes and reset pulses compared every cycle against a behavioural model.
module tb_activity_predictor;

  localparam int CNT_W      = 4;
  localparam int ON_THRESH  = 2;
  localparam int IDLE_LIMIT = 8;
  localparam int WARMUP     = 4;
  localparam int SMAX       = (1 << CNT_W) - 1;
`ifdef ACT_PRED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  activity_predictor_if bus ();

  activity_predictor #(
    .CNT_W(CNT_W), .ON_THRESH(ON_THRESH), .IDLE_LIMIT(IDLE_LIMIT), .WARMUP(WARMUP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // st: 0 warm-up, 1 active, 2 drain, 3 sleep; warm counts completed warm-up edges,
  // idle counts completed idle edges in drain, sc counts sleep entries.
  typedef struct {
    int st;
    int score;
    int warm;
    int idle;
    int sc;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t reset_model();
    mdl_t r;
    r.st = 0; r.score = 0; r.warm = 0; r.idle = 0; r.sc = 0;
    return r;
  endfunction

  function automatic mdl_t step(input mdl_t c, input logic act, input logic wk);
    mdl_t n;
    bit   wake;
    n    = c;
    wake = act || wk;
    n.score = act ? ((c.score < SMAX) ? c.score + 1 : SMAX) : ((c.score > 0) ? c.score - 1 : 0);
    n.idle  = 0;
    if (c.st == 0) begin
      n.warm = c.warm + 1;
      if (n.warm == WARMUP) n.st = 1;
    end else if (c.st == 1) begin
      if (!wake && c.score < ON_THRESH) n.st = 2;
    end else if (c.st == 2) begin
      if (wake) n.st = 1;
      else if (c.idle + 1 == IDLE_LIMIT) begin
        n.st = 3;
        n.sc = (c.sc < 65535) ? c.sc + 1 : 65535;
      end else n.idle = c.idle + 1;
    end else begin
      if (wake) n.st = 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= reset_model();
    else       m <= step(m, bus.activity, bus.wake_req);
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    chk("cyc_state",   int'(bus.state),       m.st);
    chk("cyc_predict", int'(bus.predict),     (m.st != 3) ? 1 : 0);
    chk("cyc_sleep_count", int'(bus.sleep_count), STATS ? m.sc : 0);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic a, input logic w);
    bus.activity = a;
    bus.wake_req = w;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset_check(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_state"},   int'(bus.state),       0);
    chk({tag, "_predict"}, int'(bus.predict),     1);
    chk({tag, "_sc"},      int'(bus.sleep_count), 0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int sc1;

  initial begin
    bus.activity = 1'b0;
    bus.wake_req = 1'b0;
    sc1 = STATS ? 1 : 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state",   int'(bus.state),       0);
    chk("rst_predict", int'(bus.predict),     1);
    chk("rst_sc",      int'(bus.sleep_count), 0);
    reset = 1'b0;

    // Reset then idle.
    repeat (3) cyc(0, 0);
    chk("t1_warm_e3", int'(bus.state), 0);
    cyc(0, 0);
    chk("t1_active_e4", int'(bus.state), 1);
    cyc(0, 0);
    chk("t1_drain_e5", int'(bus.state), 2);
    repeat (7) cyc(0, 0);
    chk("t1_drain_e12", int'(bus.state), 2);
    chk("t1_pred_e12", int'(bus.predict), 1);
    cyc(0, 0);
    chk("t1_sleep_e13", int'(bus.state), 3);
    chk("t1_pred_e13", int'(bus.predict), 0);
    chk("t1_sc", int'(bus.sleep_count), sc1);

    // Wake from sleep with one activity cycle.
    cyc(1, 0);
    chk("t2_state", int'(bus.state), 1);
    chk("t2_pred",  int'(bus.predict), 1);

    // Score saturates at 15; 14 idle edges keep ACTIVE, the 15th enters DRAIN.
    repeat (20) cyc(1, 0);
    chk("t3_busy_state", int'(bus.state), 1);
    repeat (14) cyc(0, 0);
    chk("t3_hold_state", int'(bus.state), 1);
    cyc(0, 0);
    chk("t3_drain_state", int'(bus.state), 2);

    // Late drain abort on the final idle cycle.
    repeat (7) cyc(0, 0);
    chk("t4_pre_state", int'(bus.state), 2);
    cyc(0, 1);
    chk("t4_state", int'(bus.state), 1);
    chk("t4_pred",  int'(bus.predict), 1);
    chk("t4_sc",    int'(bus.sleep_count), sc1);

    // Reset mid-drain, then reset while asleep.
    repeat (4) cyc(0, 0);
    chk("t5_in_drain", int'(bus.state), 2);
    pulse_reset_check("t5_drain_rst");
    repeat (13) cyc(0, 0);
    chk("t5_in_sleep", int'(bus.state), 3);
    pulse_reset_check("t5_sleep_rst");

    // Randomized phase: sparse activity so drains and sleeps occur, rare wake_req and resets.
    for (int i = 0; i < 4000; i++) begin
      logic a, w;
      if ((i / 200) % 2 == 0) a = ($urandom_range(0, 99) < 8);
      else                    a = ($urandom_range(0, 99) < 60);
      w = ($urandom_range(0, 99) < 3);
      cyc(a, w);
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
      end
    end

    bus.activity = 1'b0;
    bus.wake_req = 1'b0;
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
